// File: rtl/rv32_barrel_pc_sched_pkg.sv
// rv32_barrel_pc_sched_pkg: shared rv32 types and defaults for the barrel PC scheduler
package rv32_barrel_pc_sched_pkg;
  localparam int RV32_NUM_HARTS = 8;
  typedef logic [31:0] rv32_pc_cnt_t;
  typedef logic [31:0] rv32_register_t;
  typedef enum logic [1:0] {HART_IDLE, HART_READY, HART_INFLIGHT} hart_state_e;
endpackage

// File: rtl/rv32_barrel_pc_sched_rr_arbiter.sv
// rv32_rr_arbiter: picks the first requester at or after the pointer, wrapping modulo N
module rv32_rr_arbiter #(
  parameter int N = 8
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx
);
  logic [$clog2(N)-1:0] w_cand;
  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    w_cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_cand = i_ptr + i[$clog2(N)-1:0];
      if (i_req[w_cand]) begin
        o_gnt         = '0;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end
endmodule

// File: rtl/rv32_barrel_pc_sched.sv
// rv32_barrel_pc_sched: per-hart PC/state tracking with a round-robin fetch offer register
module rv32_barrel_pc_sched
  import rv32_barrel_pc_sched_pkg::*;
#(
  parameter int           NUM_HARTS = RV32_NUM_HARTS,
  parameter rv32_pc_cnt_t RESET_PC  = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_HARTS-1:0]         hart_en,
  output logic                         fetch_valid,
  input  logic                         fetch_ready,
  output logic [$clog2(NUM_HARTS)-1:0] fetch_hart_id,
  output rv32_pc_cnt_t                 fetch_pc,
  input  logic                         retire_valid,
  input  logic [$clog2(NUM_HARTS)-1:0] retire_hart_id,
  input  logic                         retire_has_new_pc,
  input  rv32_pc_cnt_t                 retire_new_pc,
  input  logic                         pc_wr_valid,
  input  logic [$clog2(NUM_HARTS)-1:0] pc_wr_hart_id,
  input  rv32_pc_cnt_t                 pc_wr_pc,
  output logic                         sched_err,
  output logic                         misalign_err
);
  localparam int HW = $clog2(NUM_HARTS);
  hart_state_e          r_state     [NUM_HARTS];
  hart_state_e          w_state_nxt [NUM_HARTS];
  rv32_pc_cnt_t         r_pc        [NUM_HARTS];
  rv32_pc_cnt_t         w_pc_nxt    [NUM_HARTS];
  logic                 r_offer_v;
  logic [HW-1:0]        r_offer_id;
  rv32_pc_cnt_t         r_offer_pc;
  logic [HW-1:0]        r_ptr;
  logic                 r_sched_err;
  logic                 r_misalign_err;
  logic                 w_issue;
  logic                 w_ret_ok;
  logic                 w_ret_bad;
  logic                 w_wr_bad;
  logic                 w_load;
  logic                 w_gnt_any;
  logic [NUM_HARTS-1:0] w_req;
  logic [NUM_HARTS-1:0] w_gnt;
  logic [HW-1:0]        w_gnt_idx;
  rv32_pc_cnt_t         w_ret_pc;

  assign w_issue   = r_offer_v & fetch_ready;
  assign w_ret_ok  = retire_valid & (r_state[retire_hart_id] == HART_INFLIGHT);
  assign w_ret_bad = retire_valid & ~w_ret_ok;
  assign w_wr_bad  = pc_wr_valid & (r_state[pc_wr_hart_id] != HART_IDLE);
  assign w_ret_pc  = retire_has_new_pc ? (retire_new_pc & 32'hFFFF_FFFC) : r_pc[retire_hart_id] + 32'd4;
  assign w_load    = ~r_offer_v | fetch_ready;
  assign w_gnt_any = |w_gnt;

  rv32_rr_arbiter #(.N(NUM_HARTS)) u_arb (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        r_state[h] <= HART_IDLE;
        r_pc[h]    <= RESET_PC;
      end
      r_offer_v      <= 1'b0;
      r_offer_id     <= '0;
      r_offer_pc     <= '0;
      r_ptr          <= '0;
      r_sched_err    <= 1'b0;
      r_misalign_err <= 1'b0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        r_state[h] <= w_state_nxt[h];
        r_pc[h]    <= w_pc_nxt[h];
      end
      if (w_load) begin
        r_offer_v <= w_gnt_any;
        if (w_gnt_any) begin
          r_offer_id <= w_gnt_idx;
          r_offer_pc <= r_pc[w_gnt_idx];
          r_ptr      <= w_gnt_idx + 1'b1;
        end
      end
      r_sched_err    <= r_sched_err | w_ret_bad | w_wr_bad;
      r_misalign_err <= r_misalign_err | (w_ret_ok & retire_has_new_pc & retire_new_pc[1]);
    end
  end

  // Issue wins over everything; an offered hart is READY so it can never also retire.
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      w_state_nxt[h] = r_state[h];
      w_pc_nxt[h]    = r_pc[h];
      if (w_issue && r_offer_id == h[HW-1:0])
        w_state_nxt[h] = HART_INFLIGHT;
      else if (w_ret_ok && retire_hart_id == h[HW-1:0]) begin
        w_state_nxt[h] = hart_en[h] ? HART_READY : HART_IDLE;
        w_pc_nxt[h]    = w_ret_pc;
      end else if (r_state[h] == HART_IDLE && hart_en[h])
        w_state_nxt[h] = HART_READY;
      else if (r_state[h] == HART_READY && !hart_en[h] && !(r_offer_v && r_offer_id == h[HW-1:0]))
        w_state_nxt[h] = HART_IDLE;
      if (pc_wr_valid && pc_wr_hart_id == h[HW-1:0] && r_state[h] == HART_IDLE)
        w_pc_nxt[h] = pc_wr_pc;
    end
  end

  always_comb begin
    w_req = '0;
    for (int h = 0; h < NUM_HARTS; h++)
      w_req[h] = (r_state[h] == HART_READY) && hart_en[h] && !(r_offer_v && r_offer_id == h[HW-1:0]);
  end

  assign fetch_valid   = r_offer_v;
  assign fetch_hart_id = r_offer_id;
  assign fetch_pc      = r_offer_pc;
  assign sched_err     = r_sched_err;
  assign misalign_err  = r_misalign_err;
endmodule

// File: doc/rv32_barrel_pc_sched.md
RV32_BARREL_PC_SCHED -- requirements
Module: rv32_barrel_pc_sched

Interface
REQ-001 Parameter NUM_HARTS, default 8, number of barrel harts; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC loaded into every hart at reset.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port hart_en  input  NUM_HARTS  per-hart run enable.
REQ-006 Port fetch_valid  output  1  a hart PC is offered for fetch.
REQ-007 Port fetch_ready  input  1  fetch stage accepts the offer.
REQ-008 Port fetch_hart_id  output  $clog2(NUM_HARTS)  hart of the offered PC.
REQ-009 Port fetch_pc  output  32 (rv32_pc_cnt_t)  offered PC.
REQ-010 Port retire_valid  input  1  an in-flight instruction completes.
REQ-011 Port retire_hart_id  input  $clog2(NUM_HARTS)  hart of the retiring instruction.
REQ-012 Port retire_has_new_pc  input  1  redirect flag from next-PC logic.
REQ-013 Port retire_new_pc  input  32  redirect target from next-PC logic.
REQ-014 Port pc_wr_valid / pc_wr_hart_id / pc_wr_pc  input  1 / $clog2(NUM_HARTS) / 32  PC configuration write.
REQ-015 Port sched_err  output  1  sticky protocol-error flag.
REQ-016 Port misalign_err  output  1  sticky flag: redirect target had bit 1 set.

Function
REQ-017 Each hart SHALL hold a 32-bit PC and a state in {IDLE, READY, INFLIGHT}.
REQ-018 IDLE->READY when hart_en[h]=1; READY->IDLE when hart_en[h]=0 and the hart is not held in the offer register.
REQ-019 The offer register SHALL load the next READY hart in round-robin order, starting at (last granted hart + 1) mod NUM_HARTS; fetch_valid=1 while loaded.
REQ-020 The offer register SHALL hold fetch_hart_id and fetch_pc stable while fetch_valid=1 and fetch_ready=0, regardless of hart_en changes.
REQ-021 On fetch_valid=1 and fetch_ready=1, the offered hart SHALL become INFLIGHT and the register may reload at the same edge (one issue per cycle sustained).
REQ-022 A hart becoming READY at edge k SHALL be offerable no earlier than the cycle after edge k; no hart SHALL ever be offered twice without an intervening retire.
REQ-023 On retire_valid for an INFLIGHT hart: PC <= retire_new_pc with bits [1:0] forced to 0 if retire_has_new_pc=1, else PC+4 (mod 2^32); state <= READY if hart_en=1, else IDLE.
REQ-024 misalign_err SHALL be set when an accepted redirect has bit 1 = 1; bit 0 alone SHALL be silently cleared.
REQ-025 Retire for a hart not INFLIGHT SHALL be ignored and SHALL set sched_err.
REQ-026 pc_wr_valid SHALL update the PC only if the target hart is IDLE; otherwise the write is dropped and sched_err is set.
REQ-027 A retire and an issue of different harts in the same cycle SHALL both take effect; a retiring hart SHALL NOT be issued in that same cycle.
REQ-028 PC+4 wrap from 32'hFFFF_FFFC SHALL yield 32'h0000_0000 without error.

Reset
REQ-029 On rst_n=0, asynchronously: all harts IDLE, all PCs=RESET_PC, offer register empty, fetch_valid=0, fetch_hart_id=0, fetch_pc=0, round-robin pointer so hart 0 is first, sched_err=0, misalign_err=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight state; later retires are treated as errors per REQ-025.

Structure
REQ-031 rv32_pc_cnt_t, rv32_register_t, and a hart-state enum SHALL live in the shared rv32 package; NUM_HARTS defaults from the package constant.
REQ-032 Round-robin selection SHALL be one sub-module, rv32_rr_arbiter (request vector, pointer in, grant one-hot + index out).

Verification
REQ-033 Reset then hart_en=8'hFF, fetch_ready=1, no retires -> offers harts 0..7 in order at PC 0, then fetch_valid=0.
REQ-034 Hart 3 in flight at PC 0x100; retire with has_new_pc=1, new_pc=0x203 -> hart 3 next offered at 0x200; misalign_err=1.
REQ-035 fetch_ready=0 for 5 cycles with hart 2 offered, hart_en[2] dropped -> hart 2 and PC stable all 5 cycles; issued on ready; on retire goes IDLE.
REQ-036 pc_wr to IDLE hart 5 with 0x8000 then enable -> hart 5 offered at 0x8000; pc_wr to INFLIGHT hart -> dropped, sched_err=1.
REQ-037 Retire of hart 1 never issued -> no state change, sched_err=1; retire at PC 0xFFFF_FFFC without redirect -> next offer PC 0x0.
REQ-038 Reset pulsed while 4 harts INFLIGHT -> all outputs at reset values within the same cycle; asynchronous assertion checked between clock edges.
